fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROGS, default 3: number of programs run before terminal stop.
REQ-002 SHALL have parameter BR_OPCODE, default 4'b1111: value of Instr_in[8:5] that marks a relative branch.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Init_n  input  1  reset; synchronous, active-low.
REQ-005 Start  input  1  level; request to begin the next program.
REQ-006 Halt  input  1  one-cycle pulse from the program counter; current program finished.
REQ-007 Instr_in  input  9  instruction ROM data at the current PC (combinational read).
REQ-008 Init  output  1  active-high hold-at-zero to the program counter.
REQ-009 Counter  output  2  instruction phase to the program counter; PC advances only when 0.
REQ-010 Instr_reg  output  9  latched current instruction.
REQ-011 Branch_rel_en  output  1  current instruction is a relative branch.
REQ-012 Target  output  8  branch LUT index.
REQ-013 Busy  output  1  a program is running.
REQ-014 Done  output  1  one-cycle pulse when a program completes.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSED, FINISHED.
REQ-016 IDLE: Init=1, Counter held at 1, Busy=0; Start=1 -> RUN with Init<=0.
REQ-017 RUN: Counter sequence 1->2->3->0->1; Busy=1.
REQ-018 Instr_reg SHALL load Instr_in only on a RUN edge with Counter==1; it holds otherwise.
REQ-019 Branch_rel_en SHALL be 1 only when state==RUN, Counter==0 and Instr_reg[8:5]==BR_OPCODE; it is combinational from registered state.
REQ-020 Target SHALL be {3'b000, Instr_reg[4:0]} at all times.
REQ-021 Halt=1 in RUN with Counter==0 SHALL set Counter<=1 and Done<=1 for one cycle, increment the program count, and go to PAUSED, or to FINISHED if the count reaches NUM_PROGS.
REQ-022 Halt in any other state, or with Counter!=0, SHALL be ignored.
REQ-023 PAUSED: Counter held at 1, Init=0, Busy=0; Start=1 -> RUN without asserting Init, so the PC continues from its current value.
REQ-024 FINISHED: Counter held at 1, Init=0, Busy=0; Start ignored until reset.
REQ-025 Start while in RUN SHALL be ignored.
REQ-026 If Start and Halt are both high in RUN, Halt SHALL take priority and Start SHALL be ignored that cycle.
REQ-027 The program count SHALL be 2 bits; it saturates at NUM_PROGS and never wraps.
REQ-028 Counter SHALL never be 0 outside RUN, so the PC is frozen whenever the block is not running.

Reset
REQ-029 Init_n=0 at any edge, including mid-program, SHALL force:
- state=IDLE, Counter=1, Init=1;
- Instr_reg=0, program count=0;
- Done=0, Busy=0.

Structure
REQ-030 Package fetch_pkg SHALL hold:
- the state enum;
- PHASE_FETCH=2'd1, PHASE_ADV=2'd0;
- instruction width 9 and opcode field bounds.
REQ-031 One sub-module is natural: phase_counter (2-bit counter with hold and load-to-1 inputs); everything else is inline.

Verification
REQ-032 Reset, then Start=1 for one cycle -> Init=1 during the Start edge and 0 after; Counter reads 1,2,3,0,1 on the next five cycles; Instr_reg loads ROM[0].
REQ-033 Instr_in=9'b1111_00101 latched -> at Counter==0, Branch_rel_en=1 and Target=8'd5; with Instr_in=9'b0001_00101 latched, Branch_rel_en=0.
REQ-034 Halt pulse at Counter==0 during program 1 -> next cycle Done=1, state PAUSED, Counter=1 held for 20 cycles, Init=0; Start -> RUN and Instr_reg loads the ROM word at the held PC.
REQ-035 Three Halt pulses each followed by Start -> after the third Done, FINISHED; Start held for 10 cycles causes no Counter change.
REQ-036 Init_n=0 at Counter==2 mid-program -> next cycle Counter=1, Init=1, Instr_reg=0, Busy=0.
REQ-037 Start and Halt both high at Counter==0 in RUN -> PAUSED with Done=1; Start is honoured only on a later cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller: FSM states, counter
// phase encodings and the instruction field layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_FINISHED = 2'd3
  } state_t;

  // Counter value at which the instruction is latched, and the one at which the PC advances
  localparam logic [1:0] PHASE_FETCH = 2'd1;
  localparam logic [1:0] PHASE_ADV   = 2'd0;

  localparam int INSTR_W  = 9;
  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 5;
  localparam int TGT_MSB  = 4;
  localparam int TARGET_W = 8;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_if.sv
// Handshake and datapath signals between the fetch controller (master)
// and the program counter / instruction ROM side (slave).
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic                Start;
  logic                Halt;
  logic [INSTR_W-1:0]  Instr_in;
  logic                Init;
  logic [1:0]          Counter;
  logic [INSTR_W-1:0]  Instr_reg;
  logic                Branch_rel_en;
  logic [TARGET_W-1:0] Target;
  logic                Busy;
  logic                Done;

  modport master (
    input  Start, Halt, Instr_in,
    output Init, Counter, Instr_reg, Branch_rel_en, Target, Busy, Done
  );

  modport slave (
    output Start, Halt, Instr_in,
    input  Init, Counter, Instr_reg, Branch_rel_en, Target, Busy, Done
  );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl_phase_counter.sv
// Two-bit instruction phase counter: wraps 1->2->3->0->1 while running,
// load-to-fetch-phase has priority over hold.
module phase_counter
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_hold,
  input  logic       i_load,
  output logic [1:0] o_count
);

  logic [1:0] r_count;

  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= PHASE_FETCH;
    end else if (i_load) begin
      r_count <= PHASE_FETCH;
    end else if (!i_hold) begin
      r_count <= r_count + 2'd1;
    end
  end

  assign o_count = r_count;

endmodule : phase_counter

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences instruction phases for the program counter,
// latches instructions, flags relative branches and counts finished programs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int         NUM_PROGS = 3,
  parameter logic [3:0] BR_OPCODE = 4'b1111
) (
  input  logic         CLK,
  input  logic         Init_n,
  fetch_ctrl_if.master bus
);

  state_t             r_state;
  logic               r_init;
  logic               r_done;
  logic [1:0]         r_prog_cnt;
  logic [INSTR_W-1:0] r_instr;

  logic [1:0] w_counter;
  logic       w_run;
  logic       w_halt_take;
  logic       w_last_prog;

  assign w_run       = (r_state == ST_RUN);
  assign w_halt_take = w_run && bus.Halt && (w_counter == PHASE_ADV);
  assign w_last_prog = (int'(r_prog_cnt) + 1) >= NUM_PROGS;

  // Frozen outside RUN; entering a stopped state always goes through a load, so it parks at 1
  phase_counter u_phase (
    .clk     (CLK),
    .rst_n   (Init_n),
    .i_hold  (!w_run),
    .i_load  (w_halt_take),
    .o_count (w_counter)
  );

  // NOTE: Instr_reg is a plain datapath register, so it is cleared by reset like
  // the control state; a mid-program reset must not leave a stale branch visible.
  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      r_state    <= ST_IDLE;
      r_init     <= 1'b1;
      r_done     <= 1'b0;
      r_prog_cnt <= 2'd0;
      r_instr    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_run && (w_counter == PHASE_FETCH)) r_instr <= bus.Instr_in;

      case (r_state)
        ST_IDLE: begin
          if (bus.Start) begin
            r_state <= ST_RUN;
            r_init  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Halt wins over a simultaneous Start; Start is only looked at in IDLE/PAUSED
          if (w_halt_take) begin
            r_done  <= 1'b1;
            r_state <= w_last_prog ? ST_FINISHED : ST_PAUSED;
            if (int'(r_prog_cnt) < NUM_PROGS) r_prog_cnt <= r_prog_cnt + 2'd1;
          end
        end
        ST_PAUSED: begin
          if (bus.Start) r_state <= ST_RUN;
        end
        ST_FINISHED: r_state <= ST_FINISHED;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Init          = r_init;
  assign bus.Counter       = w_counter;
  assign bus.Instr_reg     = r_instr;
  assign bus.Branch_rel_en = w_run && (w_counter == PHASE_ADV) &&
                             (r_instr[OP_MSB:OP_LSB] == BR_OPCODE);
  assign bus.Target        = {3'b000, r_instr[TGT_MSB:0]};
  assign bus.Busy          = w_run;
  assign bus.Done          = r_done;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes hand-computed output
// snapshots, a negedge monitor pops and compares them.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  typedef struct packed {
    logic       init;
    logic [1:0] ctr;
    logic [8:0] ireg;
    logic       br;
    logic       busy;
    logic       done;
  } snap_t;

  typedef struct {
    string name;
    snap_t exp;
  } item_t;

  localparam logic [8:0] R0 = 9'b1111_00101;  // branch, target 5
  localparam logic [8:0] R1 = 9'b0001_00101;  // not a branch
  localparam logic [8:0] R2 = 9'b1111_01010;  // branch, target 10
  localparam logic [8:0] R3 = 9'b0101_11111;  // not a branch, target 31

  logic CLK    = 1'b0;
  logic Init_n = 1'b0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.NUM_PROGS(3), .BR_OPCODE(4'b1111)) dut (
    .CLK    (CLK),
    .Init_n (Init_n),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // Program counter and ROM environment
  logic [8:0] rom [0:7];
  logic [7:0] pc;

  always @(posedge CLK) begin
    if (!Init_n || bus.Init) pc <= 8'd0;
    else if (bus.Counter == 2'd0) pc <= pc + 8'd1;
  end

  assign bus.Instr_in = rom[pc[2:0]];

  item_t sb[$];
  item_t m_it;
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b (init|ctr|ireg|br|busy|done|target)", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      m_it = sb.pop_front();
      check(m_it.name,
            {bus.Init, bus.Counter, bus.Instr_reg, bus.Branch_rel_en, bus.Busy, bus.Done, bus.Target},
            {m_it.exp, 3'b000, m_it.exp.ireg[4:0]});
    end
  end

  task automatic tick(input string nm, input logic init, input logic [1:0] ctr,
                      input logic [8:0] ireg, input logic br, input logic busy, input logic done);
    item_t it;
    @(posedge CLK);
    #1;
    it.name = nm;
    it.exp  = {init, ctr, ireg, br, busy, done};
    sb.push_back(it);
  endtask

  initial begin
    rom[0] = R0; rom[1] = R1; rom[2] = R2; rom[3] = R3;
    for (int k = 4; k < 8; k++) rom[k] = 9'd0;
    bus.Start = 1'b0;
    bus.Halt  = 1'b0;

    Init_n = 1'b0;
    tick("reset_a", 1, 1, 9'd0, 0, 0, 0);
    tick("reset_b", 1, 1, 9'd0, 0, 0, 0);
    Init_n = 1'b1;
    tick("idle", 1, 1, 9'd0, 0, 0, 0);

    // Program 1: start from IDLE, phases 1,2,3,0,1
    bus.Start = 1'b1;
    tick("start", 0, 1, 9'd0, 0, 1, 0);
    bus.Start = 1'b0;
    tick("p1_c2", 0, 2, R0, 0, 1, 0);
    tick("p1_c3", 0, 3, R0, 0, 1, 0);
    tick("p1_c0_branch", 0, 0, R0, 1, 1, 0);
    tick("p1_c1", 0, 1, R0, 0, 1, 0);
    tick("p1_i1_c2", 0, 2, R1, 0, 1, 0);
    bus.Halt = 1'b1;
    tick("halt_at_c2_ignored", 0, 3, R1, 0, 1, 0);
    bus.Halt = 1'b0;
    tick("p1_i1_c0_nobranch", 0, 0, R1, 0, 1, 0);
    bus.Halt = 1'b1;
    tick("halt_done_p1", 0, 1, R1, 0, 0, 1);
    bus.Halt = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus.Halt = (i == 5);
      tick("paused_hold", 0, 1, R1, 0, 0, 0);
    end
    bus.Halt = 1'b0;

    // Resume: no Init, PC continues at 2
    bus.Start = 1'b1;
    tick("resume", 0, 1, R1, 0, 1, 0);
    tick("start_in_run_ignored", 0, 2, R2, 0, 1, 0);
    bus.Start = 1'b0;
    tick("p2_c3", 0, 3, R2, 0, 1, 0);
    tick("p2_c0_branch", 0, 0, R2, 1, 1, 0);
    bus.Start = 1'b1;
    bus.Halt  = 1'b1;
    tick("start_halt_together", 0, 1, R2, 0, 0, 1);
    bus.Halt = 1'b0;
    tick("start_honoured_later", 0, 1, R2, 0, 1, 0);
    bus.Start = 1'b0;
    tick("p3_c2", 0, 2, R3, 0, 1, 0);
    tick("p3_c3", 0, 3, R3, 0, 1, 0);
    tick("p3_c0", 0, 0, R3, 0, 1, 0);
    bus.Halt = 1'b1;
    tick("finish_done", 0, 1, R3, 0, 0, 1);
    bus.Halt  = 1'b0;
    bus.Start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.Halt = (i == 3);
      tick("finished_hold", 0, 1, R3, 0, 0, 0);
    end
    bus.Start = 1'b0;
    bus.Halt  = 1'b0;

    // Reset out of FINISHED, then reset mid-program at Counter==2
    Init_n = 1'b0;
    tick("reset_from_finished", 1, 1, 9'd0, 0, 0, 0);
    Init_n = 1'b1;
    bus.Start = 1'b1;
    tick("restart", 0, 1, 9'd0, 0, 1, 0);
    bus.Start = 1'b0;
    tick("restart_c2", 0, 2, R0, 0, 1, 0);
    Init_n = 1'b0;
    tick("reset_mid_program", 1, 1, 9'd0, 0, 0, 0);
    Init_n = 1'b1;
    tick("idle_after_reset", 1, 1, 9'd0, 0, 0, 0);

    // Program count was cleared: the first Halt pauses rather than finishes
    bus.Start = 1'b1;
    tick("start3", 0, 1, 9'd0, 0, 1, 0);
    bus.Start = 1'b0;
    tick("s3_c2", 0, 2, R0, 0, 1, 0);
    tick("s3_c3", 0, 3, R0, 0, 1, 0);
    tick("s3_c0_branch", 0, 0, R0, 1, 1, 0);
    bus.Halt = 1'b1;
    tick("count_cleared_done", 0, 1, R0, 0, 0, 1);
    bus.Halt  = 1'b0;
    bus.Start = 1'b1;
    tick("paused_not_finished", 0, 1, R0, 0, 1, 0);
    bus.Start = 1'b0;

    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d snapshots left, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_ctrl
